// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, register count, the hardwired-zero
// register and the forwarding-source indices (EXE is youngest, WB oldest).
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  localparam int FWD_EXE = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

endpackage

// File: rtl/bypass_sel.sv
// One read port of the ID bypass network: NFWD-way priority match, with the
// youngest (lowest-index) matching producer winning over the register file.
module bypass_sel #(
  parameter int XLEN = 32,
  parameter int NFWD = 3
) (
  input  logic [4:0]           addr_i,
  input  logic [XLEN-1:0]      rf_rdata_i,
  input  logic [NFWD-1:0]      fwd_we_i,
  input  logic [NFWD*5-1:0]    fwd_addr_i,
  input  logic [NFWD*XLEN-1:0] fwd_data_i,
  input  logic [NFWD-1:0]      fwd_rdy_i,
  output logic [XLEN-1:0]      data_o,
  output logic                 hit_o,
  output logic                 rdy_o
);

  import cpu_pkg::REG_ZERO;

  // Scan oldest to youngest so the last overwrite is the youngest match.
  always_comb begin
    data_o = rf_rdata_i;
    hit_o  = 1'b0;
    rdy_o  = 1'b1;
    for (int s = NFWD - 1; s >= 0; s--) begin
      if (fwd_we_i[s] && (fwd_addr_i[5*s +: 5] == addr_i)) begin
        data_o = fwd_data_i[XLEN*s +: XLEN];
        hit_o  = 1'b1;
        rdy_o  = fwd_rdy_i[s];
      end
    end
    if (addr_i == REG_ZERO) begin
      data_o = '0;
      hit_o  = 1'b0;
      rdy_o  = 1'b1;
    end
  end

endmodule

// File: rtl/id_bypass_scoreboard.sv
// ID-stage operand bypass, in-flight write scoreboard and stall generation.
// Optional ID_STALL_PERF_EN adds free-running stall and RAW-stall counters.
module id_bypass_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NRD   = 2,
  parameter int NFWD  = 3,
  parameter int MAXIF = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 issue_fire,
  input  logic                 issue_we,
  input  logic [4:0]           issue_waddr,
  input  logic [NRD*5-1:0]     rd_addr,
  input  logic [NRD-1:0]       rd_need,
  input  logic [NRD*XLEN-1:0]  rf_rdata,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*5-1:0]    fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_rdy,
  input  logic                 ret_we,
  input  logic [4:0]           ret_waddr,
  output logic [NRD*XLEN-1:0]  opnd_data,
  output logic                 stall,
  output logic [NREG-1:0]      sb_busy
`ifdef ID_STALL_PERF_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          stall_raw_cnt
`endif
);

  import cpu_pkg::REG_ZERO;

  localparam int CW = $clog2(MAXIF + 1);

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  logic [NRD-1:0] portHit;
  logic [NRD-1:0] portRdy;
  logic fwdStall;
  logic rawStall;
  logic ovfStall;
  logic issueInc;
  logic retDec;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    bypass_sel #(.XLEN(XLEN), .NFWD(NFWD)) u_sel (
      .addr_i     (rd_addr[5*p +: 5]),
      .rf_rdata_i (rf_rdata[XLEN*p +: XLEN]),
      .fwd_we_i   (fwd_we),
      .fwd_addr_i (fwd_addr),
      .fwd_data_i (fwd_data),
      .fwd_rdy_i  (fwd_rdy),
      .data_o     (opnd_data[XLEN*p +: XLEN]),
      .hit_o      (portHit[p]),
      .rdy_o      (portRdy[p])
    );
  end

  for (genvar r = 0; r < NREG; r++) begin : g_busy
    assign sb_busy[r] = |cnt_q[r];
  end

  // A pending write that no forwarding source shows is a producer still
  // hidden in a multi-cycle unit, so only the scoreboard can reveal it.
  always_comb begin
    fwdStall = 1'b0;
    rawStall = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      if (rd_need[p] && (rd_addr[5*p +: 5] != REG_ZERO)) begin
        if (portHit[p] && !portRdy[p]) fwdStall = 1'b1;
        if (!portHit[p] && (cnt_q[rd_addr[5*p +: 5]] != '0)) rawStall = 1'b1;
      end
    end
  end

  assign ovfStall = issue_we && (cnt_q[issue_waddr] == CW'(MAXIF));
  assign stall    = fwdStall || rawStall || ovfStall;
  assign issueInc = issue_fire && issue_we && (issue_waddr != REG_ZERO) && !stall;
  assign retDec   = ret_we && (ret_waddr != REG_ZERO);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (r != 0) begin
        case ({issueInc && (issue_waddr == 5'(r)), retDec && (ret_waddr == 5'(r))})
          2'b10:   cnt_d[r] = cnt_q[r] + CW'(1);
          2'b01:   if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CW'(1);
          default: cnt_d[r] = cnt_q[r];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (!resetn) cnt_q[r] <= '0;
      else         cnt_q[r] <= cnt_d[r];
    end
  end

  retireUnderflow : assert property (@(posedge clk) disable iff (!resetn)
    (retDec && !flush && !(issueInc && (issue_waddr == ret_waddr)))
      |-> (cnt_q[ret_waddr] != '0));

`ifdef ID_STALL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_raw_cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt_q     <= '0;
      stall_raw_cnt_q <= '0;
    end else begin
      if (stall)    stall_cnt_q     <= stall_cnt_q + 32'd1;
      if (rawStall) stall_raw_cnt_q <= stall_raw_cnt_q + 32'd1;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign stall_raw_cnt = stall_raw_cnt_q;
`endif

endmodule

// File: tb/tb_id_bypass_scoreboard.sv
// Self-checking bench for id_bypass_scoreboard: directed scenarios plus a
// randomized run against a rule-level reference model of the scoreboard.
module tb_id_bypass_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int NRD   = 2;
  localparam int NFWD  = 3;
  localparam int MAXIF = 3;

  logic                 clk;
  logic                 resetn;
  logic                 flush;
  logic                 issue_fire;
  logic                 issue_we;
  logic [4:0]           issue_waddr;
  logic [NRD*5-1:0]     rd_addr;
  logic [NRD-1:0]       rd_need;
  logic [NRD*XLEN-1:0]  rf_rdata;
  logic [NFWD-1:0]      fwd_we;
  logic [NFWD*5-1:0]    fwd_addr;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic [NFWD-1:0]      fwd_rdy;
  logic                 ret_we;
  logic [4:0]           ret_waddr;
  logic [NRD*XLEN-1:0]  opnd_data;
  logic                 stall;
  logic [NREG-1:0]      sb_busy;
`ifdef ID_STALL_PERF_EN
  logic [31:0]          stall_cnt;
  logic [31:0]          stall_raw_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: in-flight write count per register plus perf totals.
  int          mcnt [NREG];
  logic [31:0] mStall;
  logic [31:0] mRaw;

  id_bypass_scoreboard #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NFWD(NFWD), .MAXIF(MAXIF)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .issue_fire  (issue_fire),
    .issue_we    (issue_we),
    .issue_waddr (issue_waddr),
    .rd_addr     (rd_addr),
    .rd_need     (rd_need),
    .rf_rdata    (rf_rdata),
    .fwd_we      (fwd_we),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .fwd_rdy     (fwd_rdy),
    .ret_we      (ret_we),
    .ret_waddr   (ret_waddr),
    .opnd_data   (opnd_data),
    .stall       (stall),
    .sb_busy     (sb_busy)
`ifdef ID_STALL_PERF_EN
    ,
    .stall_cnt     (stall_cnt),
    .stall_raw_cnt (stall_raw_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Index of the youngest forwarding source writing register a, or -1.
  function automatic int matchSrc(logic [4:0] a);
    for (int s = 0; s < NFWD; s++)
      if (fwd_we[s] && fwd_addr[5*s +: 5] == a) return s;
    return -1;
  endfunction

  function automatic logic [XLEN-1:0] expOpnd(int p);
    logic [4:0] a;
    int s;
    a = rd_addr[5*p +: 5];
    if (a == 5'd0) return '0;
    s = matchSrc(a);
    if (s >= 0) return fwd_data[XLEN*s +: XLEN];
    return rf_rdata[XLEN*p +: XLEN];
  endfunction

  function automatic logic expRaw();
    logic [4:0] a;
    for (int p = 0; p < NRD; p++) begin
      a = rd_addr[5*p +: 5];
      if (rd_need[p] && a != 5'd0 && matchSrc(a) < 0 && mcnt[a] != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic expStall();
    logic [4:0] a;
    int s;
    if (expRaw()) return 1'b1;
    for (int p = 0; p < NRD; p++) begin
      a = rd_addr[5*p +: 5];
      s = matchSrc(a);
      if (rd_need[p] && a != 5'd0 && s >= 0 && !fwd_rdy[s]) return 1'b1;
    end
    if (issue_we && mcnt[issue_waddr] == MAXIF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NREG-1:0] expBusy();
    logic [NREG-1:0] b;
    for (int r = 0; r < NREG; r++) b[r] = (mcnt[r] != 0);
    return b;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelEdge();
    logic inc;
    logic dec;
    inc = issue_fire && issue_we && issue_waddr != 5'd0 && !expStall();
    dec = ret_we && ret_waddr != 5'd0;
    if (!resetn) begin
      mStall = '0;
      mRaw   = '0;
    end else begin
      if (expStall()) mStall = mStall + 32'd1;
      if (expRaw())   mRaw   = mRaw + 32'd1;
    end
    if (!resetn || flush) begin
      for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    end else if (!(inc && dec && issue_waddr == ret_waddr)) begin
      if (inc) mcnt[issue_waddr] = mcnt[issue_waddr] + 1;
      if (dec && mcnt[ret_waddr] > 0) mcnt[ret_waddr] = mcnt[ret_waddr] - 1;
    end
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    flush       = 1'b0;
    issue_fire  = 1'b0;
    issue_we    = 1'b0;
    issue_waddr = '0;
    rd_addr     = '0;
    rd_need     = '0;
    rf_rdata    = '0;
    fwd_we      = '0;
    fwd_addr    = '0;
    fwd_data    = '0;
    fwd_rdy     = '0;
    ret_we      = 1'b0;
    ret_waddr   = '0;
  endtask

  task automatic resetDut();
    clearInputs();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
  endtask

  task automatic issueReg(logic [4:0] r);
    issue_fire  = 1'b1;
    issue_we    = 1'b1;
    issue_waddr = r;
    tick();
    issue_fire  = 1'b0;
    issue_we    = 1'b0;
  endtask

  task automatic retireReg(logic [4:0] r);
    ret_we    = 1'b1;
    ret_waddr = r;
    tick();
    ret_we    = 1'b0;
  endtask

  task automatic test_reset();
    clearInputs();
    resetn      = 1'b0;
    issue_fire  = 1'b1;
    issue_we    = 1'b1;
    issue_waddr = 5'd6;
    flush       = 1'b1;
    tick();
    tick();
    clearInputs();
    resetn = 1'b1;
    rd_addr[4:0]   = 5'd5;
    rf_rdata[31:0] = 32'h11;
    rd_need        = 2'b01;
    #1;
    tests++;
    if (sb_busy !== '0) begin
      fails++;
      $display("[TB] FAIL reset_busy: got %h expected 0", sb_busy);
    end
    tests++;
    if (opnd_data[31:0] !== 32'h11) begin
      fails++;
      $display("[TB] FAIL reset_opnd0: got %h expected 00000011", opnd_data[31:0]);
    end
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_stall: got %b expected 0", stall);
    end
  endtask

  task automatic test_priority();
    resetDut();
    fwd_we             = 3'b101;
    fwd_addr[4:0]      = 5'd7;
    fwd_addr[14:10]    = 5'd7;
    fwd_data[31:0]     = 32'hA;
    fwd_data[95:64]    = 32'hC;
    fwd_rdy            = 3'b111;
    rd_addr[4:0]       = 5'd7;
    rf_rdata[31:0]     = 32'hDEAD;
    rd_need            = 2'b01;
    #1;
    tests++;
    if (opnd_data[31:0] !== 32'hA || stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL prio_youngest: got opnd %h stall %b expected 0000000a stall 0",
               opnd_data[31:0], stall);
    end
    fwd_rdy = 3'b110;
    #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("[TB] FAIL prio_not_ready: got stall %b expected 1", stall);
    end
    rd_need = 2'b00;
    #1;
    tests++;
    if (stall !== 1'b0 || opnd_data[31:0] !== 32'hA) begin
      fails++;
      $display("[TB] FAIL prio_no_need: got stall %b opnd %h expected stall 0 opnd 0000000a",
               stall, opnd_data[31:0]);
    end
  endtask

  task automatic test_invisible();
    resetDut();
    issueReg(5'd9);
    tests++;
    if (sb_busy !== 32'h0000_0200) begin
      fails++;
      $display("[TB] FAIL invis_busy: got %h expected 00000200", sb_busy);
    end
    rd_addr[9:5] = 5'd9;
    rd_need      = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (stall !== 1'b1) begin
        fails++;
        $display("[TB] FAIL invis_stall cycle %0d: got %b expected 1", i, stall);
      end
      tick();
    end
    ret_we    = 1'b1;
    ret_waddr = 5'd9;
    #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("[TB] FAIL invis_retire_cycle: got %b expected 1", stall);
    end
    tick();
    ret_we = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b0 || sb_busy[9] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL invis_release: got stall %b busy9 %b expected 0 0", stall, sb_busy[9]);
    end
  endtask

  task automatic test_simultaneous();
    resetDut();
    issueReg(5'd4);
    issue_fire  = 1'b1;
    issue_we    = 1'b1;
    issue_waddr = 5'd4;
    ret_we      = 1'b1;
    ret_waddr   = 5'd4;
    tick();
    clearInputs();
    tests++;
    if (sb_busy[4] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL simul_busy: got %b expected 1", sb_busy[4]);
    end
    retireReg(5'd4);
    tests++;
    if (sb_busy[4] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL simul_net_one: got busy4 %b expected 0", sb_busy[4]);
    end
    for (int i = 0; i < MAXIF; i++) issueReg(5'd4);
    issue_fire  = 1'b1;
    issue_we    = 1'b1;
    issue_waddr = 5'd4;
    #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++;
      $display("[TB] FAIL overflow_stall: got %b expected 1", stall);
    end
    tick();
    clearInputs();
    for (int i = 0; i < MAXIF; i++) begin
      tests++;
      if (sb_busy[4] !== 1'b1) begin
        fails++;
        $display("[TB] FAIL overflow_drain %0d: got busy4 %b expected 1", i, sb_busy[4]);
      end
      retireReg(5'd4);
    end
    tests++;
    if (sb_busy[4] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL overflow_empty: got busy4 %b expected 0", sb_busy[4]);
    end
  endtask

  task automatic test_flush();
    resetDut();
    issueReg(5'd3);
    issueReg(5'd3);
    issueReg(5'd8);
    tests++;
    if (sb_busy !== 32'h0000_0108) begin
      fails++;
      $display("[TB] FAIL flush_pre: got %h expected 00000108", sb_busy);
    end
    flush       = 1'b1;
    issue_fire  = 1'b1;
    issue_we    = 1'b1;
    issue_waddr = 5'd3;
    tick();
    clearInputs();
    tests++;
    if (sb_busy !== '0) begin
      fails++;
      $display("[TB] FAIL flush_clear: got %h expected 0", sb_busy);
    end
  endtask

  task automatic test_reset_mid();
    resetDut();
    issueReg(5'd12);
    issueReg(5'd13);
    resetn      = 1'b0;
    issue_fire  = 1'b1;
    issue_we    = 1'b1;
    issue_waddr = 5'd14;
    ret_we      = 1'b1;
    ret_waddr   = 5'd12;
    tick();
    clearInputs();
    resetn = 1'b1;
    #1;
    tests++;
    if (sb_busy !== '0) begin
      fails++;
      $display("[TB] FAIL reset_mid: got %h expected 0", sb_busy);
    end
  endtask

  task automatic test_r0();
    resetDut();
    issue_fire     = 1'b1;
    issue_we       = 1'b1;
    issue_waddr    = 5'd0;
    rd_addr[4:0]   = 5'd0;
    rd_need        = 2'b01;
    rf_rdata[31:0] = 32'h5555_AAAA;
    fwd_we         = 3'b001;
    fwd_addr[4:0]  = 5'd0;
    fwd_data[31:0] = 32'h1234;
    fwd_rdy        = 3'b000;
    #1;
    tests++;
    if (opnd_data[31:0] !== 32'h0 || stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL r0_read: got opnd %h stall %b expected 0 0", opnd_data[31:0], stall);
    end
    tick();
    clearInputs();
    tests++;
    if (sb_busy !== '0) begin
      fails++;
      $display("[TB] FAIL r0_busy: got %h expected 0", sb_busy);
    end
`ifdef ID_STALL_PERF_EN
    issueReg(5'd9);
    rd_addr[4:0] = 5'd9;
    rd_need      = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    clearInputs();
    #1;
    tests++;
    if (stall_cnt !== 32'd3 || stall_raw_cnt !== 32'd3) begin
      fails++;
      $display("[TB] FAIL perf_count: got %0d/%0d expected 3/3", stall_cnt, stall_raw_cnt);
    end
`endif
  endtask

  task automatic test_random();
    int pending [$];
    logic [NRD-1:0] needR;
    resetDut();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < NRD; p++) begin
        rd_addr[5*p +: 5]     = 5'($urandom_range(0, 7));
        rf_rdata[XLEN*p +: XLEN] = $urandom;
      end
      needR = NRD'($urandom);
      rd_need = needR;
      for (int s = 0; s < NFWD; s++) begin
        fwd_addr[5*s +: 5]       = 5'($urandom_range(0, 7));
        fwd_data[XLEN*s +: XLEN] = $urandom;
      end
      fwd_we      = NFWD'($urandom);
      fwd_rdy     = ($urandom_range(0, 3) == 0) ? NFWD'($urandom) : '1;
      issue_fire  = ($urandom_range(0, 1) == 1);
      issue_we    = ($urandom_range(0, 3) != 0);
      issue_waddr = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 40) == 0);
      pending.delete();
      for (int r = 1; r < 8; r++) if (mcnt[r] > 0) pending.push_back(r);
      ret_we = (pending.size() > 0) && ($urandom_range(0, 2) != 0);
      ret_waddr = (pending.size() > 0) ?
                  5'(pending[$urandom_range(0, pending.size() - 1)]) : 5'd0;
      #1;
      for (int p = 0; p < NRD; p++) begin
        tests++;
        if (opnd_data[XLEN*p +: XLEN] !== expOpnd(p)) begin
          fails++;
          $display("[TB] FAIL rand_opnd%0d cyc %0d: got %h expected %h",
                   p, cyc, opnd_data[XLEN*p +: XLEN], expOpnd(p));
        end
      end
      tests++;
      if (stall !== expStall()) begin
        fails++;
        $display("[TB] FAIL rand_stall cyc %0d: got %b expected %b", cyc, stall, expStall());
      end
      tick();
      tests++;
      if (sb_busy !== expBusy()) begin
        fails++;
        $display("[TB] FAIL rand_busy cyc %0d: got %h expected %h", cyc, sb_busy, expBusy());
      end
`ifdef ID_STALL_PERF_EN
      tests++;
      if (stall_cnt !== mStall || stall_raw_cnt !== mRaw) begin
        fails++;
        $display("[TB] FAIL rand_perf cyc %0d: got %0d/%0d expected %0d/%0d",
                 cyc, stall_cnt, stall_raw_cnt, mStall, mRaw);
      end
`endif
    end
    clearInputs();
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    mStall = '0;
    mRaw   = '0;
    resetn = 1'b0;
    clearInputs();
    test_reset();
    test_priority();
    test_invisible();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_r0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_bypass_scoreboard.md
# id_bypass_scoreboard

Parametrised operand-bypass and interlock unit for the ID stage. It selects each source operand from the youngest valid in-flight producer, falling back to the register file. It keeps a per-register scoreboard of issued but not yet retired writes and generates the ID stall. This generalises the fixed three-source, two-port, load-only interlock of the current ID stage: forwarding depth, read-port count and in-flight depth are parameters, and multi-cycle producers (mul/div) are tracked.

## Interface
- XLEN, 32, datapath width
- NREG, 32, architectural registers; r0 is hardwired zero
- NRD, 2, operand read ports
- NFWD, 3, forwarding sources; index 0 is youngest (EXE), NFWD-1 is oldest (WB)
- MAXIF, 3, maximum in-flight writes per register; counter width is CW = clog2(MAXIF+1)
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- flush  in  1  global flush from WB (exception/ertn)
- issue_fire  in  1  ID→EXE handshake completes this cycle
- issue_we  in  1  issuing instruction writes a GPR
- issue_waddr  in  5  its destination
- rd_addr  in  NRD*5  read addresses, port p at [5p+4:5p]
- rd_need  in  NRD  port p operand is actually consumed
- rf_rdata  in  NRD*XLEN  register-file read data
- fwd_we  in  NFWD  source s holds a valid GPR write
- fwd_addr  in  NFWD*5  source s destination
- fwd_data  in  NFWD*XLEN  source s result
- fwd_rdy  in  NFWD  source s data is final (0 for a load in EXE, or a busy mul/div)
- ret_we  in  1  a write retires at WB this cycle
- ret_waddr  in  5  retiring destination
- opnd_data  out  NRD*XLEN  resolved operands
- stall  out  1  ID must hold
- sb_busy  out  NREG  bit r set when counter r ≠ 0

## Operation
- Scoreboard: one CW-bit counter per register; r0 is never counted.
  - +1 when issue_fire & issue_we & issue_waddr≠0 & ~stall.
  - −1 when ret_we & ret_waddr≠0.
  - Increment and decrement of the same register in the same cycle: unchanged.
  - Decrement at 0: hold at 0 and assert the simulation assertion.
- Operand select per port p, addr a:
  - a=0 → 0.
  - Otherwise take the lowest-index s with fwd_we[s] & fwd_addr[s]=a → fwd_data[s].
  - No match → rf_rdata[p].
- stall = OR over ports with rd_need[p] & a≠0 of any of:
  - (a) the matching source has fwd_rdy=0;
  - (b) no source matches and counter[a]≠0, meaning the producer is invisible, e.g. inside the divider;
  - (c) issue_we & counter[issue_waddr]=MAXIF (overflow guard; this term applies without port qualification).
- flush: all counters cleared at the next edge. flush dominates issue and retire in the same cycle.
- stall and opnd_data are combinational from inputs and current scoreboard state.

## Timing
- Reset: all counters 0 → sb_busy=0.
- Idle inputs after reset → stall=0 and opnd_data = rf_rdata (or 0 for r0).
- Scoreboard update visible on sb_busy one cycle after the issue/retire edge.
- Zero-latency bypass: producer data is usable by ID the same cycle fwd_rdy rises.
- Reset mid-operation: counters zeroed regardless of flush, issue or retire.
- Retire and re-issue to the same register in the same cycle: net count unchanged.

## Configuration
- ID_STALL_PERF_EN defined: adds outputs stall_cnt (32) and stall_raw_cnt (32).
  - stall_cnt counts cycles with stall=1.
  - stall_raw_cnt counts cycles stalled by term (b).
  - Both are synchronous-reset to 0, wrap at 2^32, and are not cleared by flush.
- ID_STALL_PERF_EN undefined: no counters and no ports.

## Structure
- Shared package `cpu_pkg`: XLEN, NREG, the REG_ZERO constant, and the fwd-source index constants FWD_EXE=0, FWD_MEM=1, FWD_WB=2.
- One sub-module, `bypass_sel`: a parametrised NFWD-way priority match and mux for one port, instantiated NRD times via generate.
- Scoreboard counters, stall logic and perf counters stay in the top module.

## Test plan
- After reset: rd_addr0=5, rf_rdata0=0x11, no fwd → opnd0=0x11, stall=0, sb_busy=0.
- Priority: fwd0 and fwd2 both write r7 (0xA, 0xC), both rdy → opnd=0xA. Same with fwd0 not rdy and rd_need=1 → stall=1. With rd_need=0 → stall=0.
- Invisible producer: issue r9, no fwd matches r9, read r9 → stall=1 until ret_we r9. Next cycle stall=0 and sb_busy[9]=0.
- Simultaneous events: counter[4]=1, issue r4 and retire r4 in the same cycle → counter stays 1. Issue MAXIF writes to r4 then attempt one more → stall=1.
- flush with counters {r3:2, r8:1} → all 0 next cycle. A concurrent issue of r3 is not counted.
- r0: issue and read r0 → opnd=0, stall=0, sb_busy[0]=0. With ID_STALL_PERF_EN, 3 stalled cycles → stall_cnt=3.
